// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one I-cache word request at a time and
// presents the returned word to decode until it is consumed or squashed.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;   // the outstanding response belongs to a redirected-away path
  logic [31:0] target;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // NOTE: all state uses non-blocking assignments so every branch below sees
  // the pre-edge values of state, pc and drop regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      pc_out      <= RESET_PC;
    end else if (redirect_en) begin
      pc <= target;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) begin
            state <= WAIT;
            drop  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        HOLD: begin
          instr_valid <= 1'b0;
          instruction <= NOP_INSTR;
          state       <= REQ;
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= pc;
              pc          <= pc + 32'd4;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level fetch model checked every cycle,
// a responsive I-cache model, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect_en, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc_out;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc_out;

  int passed = 0;
  int total  = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .pc_out(pc_out)
  );

  // Second instance starting at the top of the address space (wrap check).
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(w_valid), .instruction(w_instr), .pc_out(w_pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'h0093};
  endfunction

  // ---------------- I-cache model ----------------
  int          lat = 1;
  int          cd = 0;
  logic        fire_next = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  logic        inject = 1'b0;
  logic [31:0] inject_data = 32'h0;

  always begin
    @(posedge clk);
    #2;
    if (fire_next) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(resp_addr);
    end else begin
      imem_rvalid = inject;
      imem_rdata  = inject ? inject_data : 32'h0;
    end
  end

  // ---------------- behavioural fetch model ----------------
  // Tracks what the fetch stage is doing in transaction terms: just out of
  // reset, asking for a word, awaiting a reply (possibly stale), or presenting.
  logic        m_boot, m_asking, m_busy, m_stale, m_valid;
  logic [31:0] m_pc, m_instr, m_pcout, m_old;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_boot = 1'b1; m_asking = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
      m_pc = 32'h0; m_instr = NOP; m_pcout = 32'h0;
      cd = 0;
    end
    check("cycle {req,addr,valid,instr,pc_out}",
          {imem_req, imem_addr, instr_valid, instruction, pc_out},
          {m_asking, m_pc, m_valid, m_instr, m_pcout});
    fire_next = 1'b0;
    if (reset_n) begin
      if (imem_req && imem_ready) begin
        cd = lat;
        resp_addr = imem_addr;
      end
      if (cd > 0) begin
        cd--;
        fire_next = (cd == 0);
      end
      m_old = m_pc;
      if (redirect_en) m_pc = {redirect_pc[31:2], 2'b00};
      if (m_boot) begin
        m_boot = 1'b0;
        m_asking = 1'b1;
      end else if (m_asking) begin
        if (imem_ready) begin
          m_asking = 1'b0;
          m_busy   = 1'b1;
          m_stale  = redirect_en;
        end
      end else if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 1'b0;
          if (m_stale || redirect_en) begin
            m_stale  = 1'b0;
            m_asking = 1'b1;
          end else begin
            m_valid = 1'b1;
            m_instr = imem_rdata;
            m_pcout = m_old;
            m_pc    = m_old + 32'd4;
          end
        end else if (redirect_en) begin
          m_stale = 1'b1;
        end
      end else if (m_valid) begin
        if (redirect_en || !stall) begin
          m_valid  = 1'b0;
          m_instr  = NOP;
          m_asking = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!instr_valid && n < max) begin
      cyc();
      n++;
    end
    check("wait_valid", {127'h0, instr_valid}, 128'h1);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_en = 1'b1;
    redirect_pc = t;
    cyc();
    redirect_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) cyc();
    check("rst valid", {127'h0, instr_valid}, 128'h0);
    check("rst instr", {96'h0, instruction}, {96'h0, NOP});
    check("rst pc_out", {96'h0, pc_out}, 128'h0);
    check("rst req", {127'h0, imem_req}, 128'h0);
    check("rst wrap addr", {96'h0, w_addr}, {96'h0, 32'hFFFF_FFFC});

    // T1: first fetch
    reset_n = 1'b1;
    cyc();
    check("t1 req addr", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h0});
    wait_valid(10);
    check("t1 instr", {96'h0, instruction}, {96'h0, 32'h0050_0093});
    check("t1 pc_out", {96'h0, pc_out}, 128'h0);
    check("t1 next addr", {96'h0, imem_addr}, 128'h4);
    check("t5 wrap pc_out", {96'h0, w_pc_out}, {96'h0, 32'hFFFF_FFFC});
    check("t5 wrap next addr", {96'h0, w_addr}, 128'h0);

    // T2: stall in HOLD
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2 held", {62'h0, imem_req, instr_valid, instruction, pc_out},
            {62'h0, 1'b0, 1'b1, 32'h0050_0093, 32'h0});
    end
    stall = 1'b0;
    cyc();
    check("t2 release", {94'h0, imem_req, instr_valid, imem_addr}, {94'h0, 1'b1, 1'b0, 32'h4});

    // T3: redirect while waiting on a slow response
    lat = 3;
    cyc();
    check("t3 in wait", {127'h0, imem_req}, 128'h0);
    lat = 1;
    redirect(32'h0000_0103);
    for (int i = 0; i < 10 && !imem_req; i++) begin
      check("t3 no valid", {127'h0, instr_valid}, 128'h0);
      cyc();
    end
    check("t3 refetch addr", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h100});
    wait_valid(10);
    check("t3 pc_out", {64'h0, pc_out, instruction}, {64'h0, 32'h100, 32'h0100_0093});

    // T4: redirect and consume in the same HOLD cycle
    redirect(32'h0000_0200);
    check("t4 squash", {62'h0, instr_valid, imem_req, instruction, imem_addr},
          {62'h0, 1'b0, 1'b1, NOP, 32'h200});
    wait_valid(10);
    check("t4 pc_out", {96'h0, pc_out}, 128'h200);

    // Redirect in HOLD while stalled still squashes
    stall = 1'b1;
    redirect(32'h0000_0300);
    check("hold stall squash", {94'h0, instr_valid, imem_req, imem_addr}, {94'h0, 1'b0, 1'b1, 32'h300});
    stall = 1'b0;

    // REQ without ready holds the address; redirect with accept drops the reply
    imem_ready = 1'b0;
    repeat (2) cyc();
    check("req hold", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'h300});
    imem_ready = 1'b1;
    redirect(32'hFFFF_FFFE);
    check("req redirect wait", {126'h0, imem_req, instr_valid}, 128'h0);
    cyc();
    check("req redirect refetch", {95'h0, imem_req, imem_addr}, {95'h0, 1'b1, 32'hFFFF_FFFC});
    wait_valid(10);
    check("wrap pc_out", {64'h0, pc_out, imem_addr}, {64'h0, 32'hFFFF_FFFC, 32'h0});

    // T6: reset mid-WAIT with a late response
    cyc();
    lat = 5;
    cyc();
    check("t6 in wait", {127'h0, imem_req}, 128'h0);
    reset_n = 1'b0;
    imem_ready = 1'b0;
    #1;
    check("t6 async rst", {62'h0, instr_valid, imem_req, instruction, imem_addr},
          {62'h0, 1'b0, 1'b0, NOP, 32'h0});
    cyc();
    reset_n = 1'b1;
    lat = 1;
    cyc();
    inject_data = 32'hDEAD_BEEF;
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    check("t6 late ignored", {94'h0, instr_valid, imem_req, imem_addr}, {94'h0, 1'b0, 1'b1, 32'h0});
    check("t6 wrap addr", {96'h0, w_addr}, {96'h0, 32'hFFFF_FFFC});
    imem_ready = 1'b1;
    wait_valid(10);
    check("t6 refetch", {64'h0, pc_out, instruction}, {64'h0, 32'h0, 32'h0050_0093});

    repeat (2) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
